// File: rtl/majority_window_filter.sv
// Sliding-window majority voter over NUM_CH independent bit streams.
// Each channel keeps its last WINDOW accepted samples and a running count of
// ones; the registered vote is 1 when that count reaches THRESHOLD. Typically
// used to debounce sampled status lines before they reach control logic.
module majority_window_filter #(
  parameter int NUM_CH    = 4,
  parameter int WINDOW    = 5,
  parameter int THRESHOLD = WINDOW / 2 + 1,
  parameter int CNT_W     = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] in_bits,
  output logic              out_valid,
  output logic [NUM_CH-1:0] out_bits,
  output logic              window_full
);

  // One extra bit on the count arithmetic so cnt+1 before the subtraction
  // cannot wrap when the window is all ones.
  localparam logic [CNT_W:0]   L_THR   = (CNT_W + 1)'(THRESHOLD);
  localparam logic [CNT_W:0]   L_WIN_W = (CNT_W + 1)'(WINDOW);
  localparam logic [CNT_W-1:0] L_WIN   = CNT_W'(WINDOW);

  logic [WINDOW-1:0] r_hist [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_fill;
  logic              r_out_valid;
  logic [NUM_CH-1:0] r_out_bits;
  logic              r_window_full;

  logic [WINDOW-1:0] w_hist_next [NUM_CH];
  logic [CNT_W:0]    w_sum       [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_next  [NUM_CH];
  logic [NUM_CH-1:0] w_vote;
  logic [CNT_W-1:0]  w_fill_next;
  logic              w_full_next;

  // Next history, running count and vote per channel, plus the shared fill level.
  // History clears to zero, so subtracting the outgoing bit is exact even
  // before the window has filled.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_hist_next[c] = {r_hist[c][WINDOW-2:0], in_bits[c]};
      w_sum[c]       = {1'b0, r_cnt[c]}
                     + {{CNT_W{1'b0}}, in_bits[c]}
                     - {{CNT_W{1'b0}}, r_hist[c][WINDOW-1]};
      w_cnt_next[c]  = w_sum[c][CNT_W-1:0];
      w_vote[c]      = (w_sum[c] >= L_THR);
    end
    w_fill_next = (r_fill == L_WIN) ? r_fill : r_fill + 1'b1;
    w_full_next = (w_fill_next == L_WIN);
  end

  // State and output registers: clear on reset or clr, update only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_fill        <= '0;
      r_out_valid   <= 1'b0;
      r_out_bits    <= '0;
      r_window_full <= 1'b0;
    end else if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_fill        <= '0;
      r_out_valid   <= 1'b0;
      r_out_bits    <= '0;
      r_window_full <= 1'b0;
    end else if (in_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= w_hist_next[c];
        r_cnt[c]  <= w_cnt_next[c];
      end
      r_fill        <= w_fill_next;
      r_out_valid   <= w_full_next;
      r_out_bits    <= w_vote;
      r_window_full <= w_full_next;
    end else begin
      r_out_valid   <= 1'b0;
    end
  end

  // Running count must stay within 0..WINDOW; underflow wraps high and is caught too.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && in_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        assert (w_sum[c] <= L_WIN_W);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_bits    = r_out_bits;
  assign window_full = r_window_full;

endmodule

// File: tb/tb_majority_window_filter.sv
// Testbench for majority_window_filter: two instances (WINDOW=5/THRESHOLD=3
// and WINDOW=7/THRESHOLD=2) share one stimulus stream; a popcount model of
// each window predicts every cycle's outputs into a scoreboard queue.
module tb_majority_window_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [3:0] in_bits;

  logic       o_valid0, o_full0;
  logic [3:0] o_bits0;
  logic       o_valid1, o_full1;
  logic [3:0] o_bits1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] bits;
    logic       full;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          mw [2] = '{5, 7};
  int          mt [2] = '{3, 2};
  logic [31:0] m_hist [2][4];
  int          m_fill [2];
  logic [3:0]  m_out  [2];

  majority_window_filter #(.NUM_CH(4), .WINDOW(5), .THRESHOLD(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits),
    .out_valid(o_valid0), .out_bits(o_bits0), .window_full(o_full0)
  );

  majority_window_filter #(.NUM_CH(4), .WINDOW(7), .THRESHOLD(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bits(in_bits),
    .out_valid(o_valid1), .out_bits(o_bits1), .window_full(o_full1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) m_hist[d][ch] = '0;
      m_fill[d] = 0;
      m_out[d]  = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_update(input logic v, input logic [3:0] b, input logic c);
    exp_t e;
    int   pop;
    for (int d = 0; d < 2; d++) begin
      e.v = 1'b0;
      if (c) begin
        for (int ch = 0; ch < 4; ch++) m_hist[d][ch] = '0;
        m_fill[d] = 0;
        m_out[d]  = '0;
      end else if (v) begin
        for (int ch = 0; ch < 4; ch++) begin
          m_hist[d][ch] = ((m_hist[d][ch] << 1) | {31'd0, b[ch]}) & ((32'd1 << mw[d]) - 32'd1);
          pop = 0;
          for (int k = 0; k < mw[d]; k++) pop += int'(m_hist[d][ch][k]);
          m_out[d][ch] = (pop >= mt[d]);
        end
        if (m_fill[d] < mw[d]) m_fill[d]++;
        e.v = (m_fill[d] == mw[d]);
      end
      e.bits = m_out[d];
      e.full = (m_fill[d] == mw[d]);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0) begin
      chk("sb_empty", 32'(q0.size() + q1.size()), 32'd2);
      return;
    end
    e = q0.pop_front();
    chk("d0_valid", 32'(o_valid0), 32'(e.v));
    chk("d0_bits",  32'(o_bits0),  32'(e.bits));
    chk("d0_full",  32'(o_full0),  32'(e.full));
    e = q1.pop_front();
    chk("d1_valid", 32'(o_valid1), 32'(e.v));
    chk("d1_bits",  32'(o_bits1),  32'(e.bits));
    chk("d1_full",  32'(o_full1),  32'(e.full));
  endtask

  // Called at posedge+1; drives one cycle, predicts, then checks after the next edge.
  task automatic step(input logic v, input logic [3:0] b, input logic c);
    in_valid = v;
    in_bits  = b;
    clr      = c;
    model_update(v, b, c);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, 32'(o_valid0), 32'd0);
    chk({tag, "_b0"}, 32'(o_bits0),  32'd0);
    chk({tag, "_f0"}, 32'(o_full0),  32'd0);
    chk({tag, "_v1"}, 32'(o_valid1), 32'd0);
    chk({tag, "_b1"}, 32'(o_bits1),  32'd0);
    chk({tag, "_f1"}, 32'(o_full1),  32'd0);
  endtask

  logic [3:0] ch0_seq [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  logic [3:0] ch1_seq [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    // Reset asserted with random inputs on the pins
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    in_bits  = 4'($urandom);
    clr      = 1'($urandom);
    #1;
    chk_zero("rst_init");
    @(posedge clk); @(posedge clk); #1;
    chk_zero("rst_hold");
    in_valid = 1'b0;
    clr      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_zero("rst_rel");

    // Warm-up: four accepts give no vote, the fifth gives the first one
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF, 1'b0);
      chk("warm_valid", 32'(o_valid0), 32'd0);
    end
    step(1'b1, 4'hF, 1'b0);
    chk("warm5_valid", 32'(o_valid0), 32'd1);
    chk("warm5_bits",  32'(o_bits0),  32'hF);
    chk("warm5_full",  32'(o_full0),  32'd1);

    // Slide: restart, ch0 = 1,1,1,0,0,0 and ch1 alternating
    step(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ch0_seq[i] | (ch1_seq[i] << 1), 1'b0);
      if (i == 4) begin
        chk("slide_ch0_hi", 32'(o_bits0[0]), 32'd1);
        chk("slide_ch1_a",  32'(o_bits0[1]), 32'd1);
      end
      if (i == 5) begin
        chk("slide_ch0_lo", 32'(o_bits0[0]), 32'd0);
        chk("slide_ch1_b",  32'(o_bits0[1]), 32'd0);
      end
      if (i == 6) chk("slide_ch1_c", 32'(o_bits0[1]), 32'd1);
      if (i == 7) chk("slide_ch1_d", 32'(o_bits0[1]), 32'd0);
    end

    // Gaps: three idle cycles, then the vote resumes
    step(1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom), 1'b0);
      chk("gap_valid", 32'(o_valid0), 32'd0);
    end
    step(1'b1, 4'hA, 1'b0);
    chk("gap_resume", 32'(o_valid0), 32'd1);

    // clr with in_valid on a full window drops the sample and restarts warm-up
    step(1'b1, 4'hF, 1'b1);
    chk("clr_full0", 32'(o_full0), 32'd0);
    chk("clr_full1", 32'(o_full1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF, 1'b0);
      chk("clr_warm", 32'(o_valid0), 32'd0);
    end
    step(1'b1, 4'hF, 1'b0);
    chk("clr_first", 32'(o_valid0), 32'd1);

    // Random stream with sparse clears
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 63) == 0));
    end

    // Reset mid-stream: outputs drop at once, nothing retained
    for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 1'b0);
    in_valid = 1'b1;
    in_bits  = 4'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    chk_zero("rst_mid_hold");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) step(1'b1, 4'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
